// File: rtl/estendedor_de_pulso_ativo_baixo_pkg.sv
// Shared types and default widths for the strobe extender and the button edge-detection path.
package estendedor_de_pulso_ativo_baixo_pkg;

    typedef enum logic [1:0] {
        EST_OCIOSO    = 2'd0,
        EST_ATIVO     = 2'd1,
        EST_INTERVALO = 2'd2
    } estado_t;

    localparam int LARGURA_PULSO_PADRAO = 4;
    localparam int INTERVALO_PADRAO     = 2;
    localparam int MAX_PENDENTES_PADRAO = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/estendedor_de_pulso_ativo_baixo_if.sv
// Request/strobe bundle between the control unit (master) and the strobe extender (slave).
// Semantics: every clk cycle with pulso_entrada=1 is one request; there is no ready, so a
// request the extender cannot take is dropped and reported through the sticky estouro flag.
interface estendedor_de_pulso_ativo_baixo_if #(
    parameter int MAX_PENDENTES = estendedor_de_pulso_ativo_baixo_pkg::MAX_PENDENTES_PADRAO
);
    localparam int PEND_W = $clog2(MAX_PENDENTES + 1);

    logic                                      pulso_entrada;
    logic                                      saida_n;
    logic                                      ocupado;
    logic [PEND_W-1:0]                         pendentes;
    logic                                      estouro;
    estendedor_de_pulso_ativo_baixo_pkg::estado_t estado;

    modport master (
        output pulso_entrada,
        input  saida_n,
        input  ocupado,
        input  pendentes,
        input  estouro,
        input  estado
    );

    modport slave (
        input  pulso_entrada,
        output saida_n,
        output ocupado,
        output pendentes,
        output estouro,
        output estado
    );

endinterface

// File: rtl/estendedor_de_pulso_ativo_baixo_contador_descendente.sv
// Loadable down-counter with a zero flag; saturates at zero when decremented further.
module contador_descendente #(
    parameter int LARGURA = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               carregar,
    input  logic               decrementar,
    input  logic [LARGURA-1:0] valor,
    output logic               zero
);

    logic [LARGURA-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (carregar) begin
            cont_d = valor;
        end else if (decrementar && (cont_q != '0)) begin
            cont_d = cont_q - LARGURA'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign zero = (cont_q == '0);

endmodule

// File: rtl/estendedor_de_pulso_ativo_baixo.sv
// Active-low strobe extender: each request becomes a LARGURA_PULSO-cycle low strobe followed by an
// INTERVALO-cycle high gap. Define ESTENDEDOR_FILA_EN to queue requests that arrive while busy.
module estendedor_de_pulso_ativo_baixo
    import estendedor_de_pulso_ativo_baixo_pkg::*;
#(
    parameter int LARGURA_PULSO = LARGURA_PULSO_PADRAO,
    parameter int INTERVALO     = INTERVALO_PADRAO,
    parameter int MAX_PENDENTES = MAX_PENDENTES_PADRAO
) (
    input logic                              clk,
    input logic                              reset,
    estendedor_de_pulso_ativo_baixo_if.slave bus
);

    localparam int CONT_W = $clog2(max_int(LARGURA_PULSO, INTERVALO) + 1);
    localparam int PEND_W = $clog2(MAX_PENDENTES + 1);
    localparam logic [CONT_W-1:0] CARGA_ATIVO     = CONT_W'(LARGURA_PULSO - 1);
    localparam logic [CONT_W-1:0] CARGA_INTERVALO = CONT_W'(INTERVALO - 1);

    estado_t estado_q, estado_d;
    logic    saida_n_q, saida_n_d;
    logic    ocupado_q, ocupado_d;
    logic    estouro_q, estouro_d;

    logic              cont_carregar;
    logic              cont_decrementar;
    logic [CONT_W-1:0] cont_valor;
    logic              cont_zero;

    logic pedido;
    logic ultimo_intervalo;
    logic pedido_ocupado;
    logic tem_pendente;
    logic descarta;

    contador_descendente #(
        .LARGURA (CONT_W)
    ) u_cont (
        .clk         (clk),
        .reset       (reset),
        .carregar    (cont_carregar),
        .decrementar (cont_decrementar),
        .valor       (cont_valor),
        .zero        (cont_zero)
    );

    assign pedido           = bus.pulso_entrada;
    assign ultimo_intervalo = (estado_q == EST_INTERVALO) && cont_zero;
    // A request in the last gap cycle with nothing queued starts the next strobe itself.
    assign pedido_ocupado   = pedido && (estado_q != EST_OCIOSO)
                              && !(ultimo_intervalo && !tem_pendente);

`ifdef ESTENDEDOR_FILA_EN
    logic [PEND_W-1:0] pendentes_q, pendentes_d;
    logic              consome;
    logic              enfileira;

    assign tem_pendente = (pendentes_q != '0);
    assign consome      = ultimo_intervalo && tem_pendente;
    // A slot freed by a strobe starting this cycle can take the incoming request even when full.
    assign enfileira    = pedido_ocupado
                          && ((pendentes_q < PEND_W'(MAX_PENDENTES)) || consome);
    assign descarta     = pedido_ocupado && !enfileira;

    always_comb begin
        pendentes_d = pendentes_q;
        if (enfileira && !consome) begin
            pendentes_d = pendentes_q + PEND_W'(1);
        end else if (!enfileira && consome) begin
            pendentes_d = pendentes_q - PEND_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendentes_q <= '0;
        end else begin
            pendentes_q <= pendentes_d;
        end
    end

    assign bus.pendentes = pendentes_q;
`else
    assign tem_pendente  = 1'b0;
    assign descarta      = pedido_ocupado;
    assign bus.pendentes = '0;
`endif

    always_comb begin
        estado_d         = estado_q;
        cont_carregar    = 1'b0;
        cont_decrementar = 1'b0;
        cont_valor       = '0;
        case (estado_q)
            EST_OCIOSO: begin
                if (pedido) begin
                    estado_d      = EST_ATIVO;
                    cont_carregar = 1'b1;
                    cont_valor    = CARGA_ATIVO;
                end
            end
            EST_ATIVO: begin
                if (cont_zero) begin
                    estado_d      = EST_INTERVALO;
                    cont_carregar = 1'b1;
                    cont_valor    = CARGA_INTERVALO;
                end else begin
                    cont_decrementar = 1'b1;
                end
            end
            EST_INTERVALO: begin
                if (cont_zero) begin
                    if (tem_pendente || pedido) begin
                        estado_d      = EST_ATIVO;
                        cont_carregar = 1'b1;
                        cont_valor    = CARGA_ATIVO;
                    end else begin
                        estado_d = EST_OCIOSO;
                    end
                end else begin
                    cont_decrementar = 1'b1;
                end
            end
            default: begin
                estado_d = EST_OCIOSO;
            end
        endcase
    end

    // Outputs are registered from the next state so they toggle on the same edge as the FSM.
    always_comb begin
        saida_n_d = (estado_d != EST_ATIVO);
        ocupado_d = (estado_d != EST_OCIOSO);
        estouro_d = estouro_q | descarta;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= EST_OCIOSO;
            saida_n_q <= 1'b1;
            ocupado_q <= 1'b0;
            estouro_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            saida_n_q <= saida_n_d;
            ocupado_q <= ocupado_d;
            estouro_q <= estouro_d;
        end
    end

    assign bus.saida_n = saida_n_q;
    assign bus.ocupado = ocupado_q;
    assign bus.estouro = estouro_q;
    assign bus.estado  = estado_q;

endmodule

// File: tb/tb_estendedor_de_pulso_ativo_baixo.sv
// Bench for the strobe extender: directed scenarios plus random requests against a schedule model.
module tb_estendedor_de_pulso_ativo_baixo;
    import estendedor_de_pulso_ativo_baixo_pkg::*;

    localparam int L = LARGURA_PULSO_PADRAO;
    localparam int I = INTERVALO_PADRAO;
    localparam int M = MAX_PENDENTES_PADRAO;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    estendedor_de_pulso_ativo_baixo_if #(.MAX_PENDENTES(M)) bus_if ();

    estendedor_de_pulso_ativo_baixo #(
        .LARGURA_PULSO (L),
        .INTERVALO     (I),
        .MAX_PENDENTES (M)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // Model: every accepted request is a scheduled strobe with a start cycle.
    typedef struct {
        int t_req;
        int ini;
        bit fila;
    } strobe_t;

    strobe_t agenda[$];
    int      fim_ocupado;
    int      primeiro_descarte;
    int      ciclo;
    int      n_assert = 0;
    int      n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s ciclo=%0d observed=%0d expected=%0d", tag, ciclo, obs, exp_v);
        end
    endtask

    task automatic model_pedido(input int t);
`ifdef ESTENDEDOR_FILA_EN
        int n;
`endif
        if (t + 1 >= fim_ocupado) begin
            agenda.push_back('{t_req: t, ini: t + 1, fila: 1'b0});
            fim_ocupado = t + 1 + L + I;
        end else begin
`ifdef ESTENDEDOR_FILA_EN
            n = 0;
            foreach (agenda[k]) begin
                if (agenda[k].fila && agenda[k].t_req < t && agenda[k].ini > t + 1) n++;
            end
            if (n < M) begin
                agenda.push_back('{t_req: t, ini: fim_ocupado, fila: 1'b1});
                fim_ocupado = fim_ocupado + L + I;
            end else if (primeiro_descarte > t) begin
                primeiro_descarte = t;
            end
`else
            if (primeiro_descarte > t) primeiro_descarte = t;
`endif
        end
    endtask

    task automatic conferir();
        logic saida_exp;
        logic ocup_exp;
        int   pend_exp;
        saida_exp = 1'b1;
        ocup_exp  = 1'b0;
        pend_exp  = 0;
        foreach (agenda[k]) begin
            if (agenda[k].ini <= ciclo && ciclo < agenda[k].ini + L) saida_exp = 1'b0;
            if (agenda[k].ini <= ciclo && ciclo < agenda[k].ini + L + I) ocup_exp = 1'b1;
            if (agenda[k].fila && agenda[k].t_req < ciclo && agenda[k].ini > ciclo) pend_exp++;
        end
        chk("saida_n", 32'(bus_if.saida_n), 32'(saida_exp));
        chk("ocupado", 32'(bus_if.ocupado), 32'(ocup_exp));
        chk("pendentes", 32'(bus_if.pendentes), pend_exp);
        chk("estouro", 32'(bus_if.estouro), 32'(primeiro_descarte < ciclo));
        chk("estado_ocioso", 32'(bus_if.estado == EST_OCIOSO), 32'(!ocup_exp));
        chk("estado_ativo", 32'(bus_if.estado == EST_ATIVO), 32'(!saida_exp));
    endtask

    task automatic tick(input logic p);
        bus_if.pulso_entrada = p;
        if (p) model_pedido(ciclo);
        @(posedge clk);
        #1;
        ciclo++;
        conferir();
    endtask

    task automatic aplicar_reset();
        bus_if.pulso_entrada = 1'b0;
        reset = 1'b1;
        #1;
        agenda.delete();
        fim_ocupado       = 0;
        primeiro_descarte = 1 << 30;
        ciclo             = 0;
        conferir();
        repeat (2) @(posedge clk);
        #1;
        conferir();
        reset = 1'b0;
    endtask

    task automatic cena(input logic [63:0] mascara, input int n);
        for (int k = 0; k < n; k++) tick(mascara[k]);
    endtask

    initial begin
        int dens;

        aplicar_reset();
        // Single strobe from a pulse at cycle 10.
        cena(64'h0000_0400, 24);

        // Pulses at 10, 12, 13: back-to-back queued strobes, or drops without the queue.
        aplicar_reset();
        cena(64'h0000_3400, 34);

        // Pulses at 10..15: overflow of a three-deep queue.
        aplicar_reset();
        cena(64'h0000_FC00, 40);

        // Pulses at 10, 12, 16: mid-strobe request and a request in the final gap cycle.
        aplicar_reset();
        cena(64'h0001_1400, 30);

        // Reset asserted at cycle 13 while requests are outstanding, then silence.
        aplicar_reset();
        cena(64'h0000_1C00, 13);
        aplicar_reset();
        cena(64'h0, 20);

        // Continuous requests.
        aplicar_reset();
        repeat (40) tick(1'b1);
        repeat (30) tick(1'b0);

        // Random requests at several densities.
        for (int seg = 0; seg < 3; seg++) begin
            dens = (seg == 0) ? 15 : ((seg == 1) ? 50 : 90);
            aplicar_reset();
            repeat (200) tick(logic'($urandom_range(0, 99) < dens));
            repeat (30) tick(1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
